conv_neuron: RTL and testbench

//   Single 4-tap convolution neuron for the simple ML accelerator datapath.

---
 rtl/conv_neuron.sv | 66 ++++++
 tb/tb_conv_neuron.sv | 125 ++++++++++++
 2 files changed

// File: rtl/conv_neuron.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_neuron: 4-tap signed MAC, shift, saturate, optional ReLU, 2 stages.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_neuron #(
  parameter int DATA_W    = 8,
  parameter int N_TAPS    = 4,
  parameter int OUT_SHIFT = 0,
  parameter int RELU_EN   = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_TAPS*DATA_W-1:0]           kernel,
  input  logic [N_TAPS-1:0][DATA_W-1:0]      pixels,
  output logic [DATA_W-1:0]                  convResult
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(N_TAPS);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic [N_TAPS-1:0][PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0]       shifted;
  logic signed [DATA_W-1:0]      sat;
  logic [DATA_W-1:0]             result_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        prod[i] <= PROD_W'($signed(kernel[DATA_W*i +: DATA_W]) * $signed(pixels[i]));
      end
    end
  end

  // The sum is wide enough to be exact, so clamping is the only overflow handling.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      sum = sum + SUM_W'($signed(prod[i]));
    end
    shifted = sum >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
    result_next = (RELU_EN != 0 && sat[DATA_W-1]) ? '0 : sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      convResult <= '0;
    end else begin
      convResult <= result_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_neuron.sv
`default_nettype none
// Scoreboard bench for conv_neuron: one default instance and one with ReLU enabled.
module tb_conv_neuron;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          kernel;
  logic [3:0][7:0]      pixels;
  logic [7:0]           res;
  logic [7:0]           res_relu;

  always #5 clk = ~clk;

  conv_neuron #(.DATA_W(8), .N_TAPS(4), .OUT_SHIFT(0), .RELU_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .pixels(pixels), .convResult(res)
  );

  conv_neuron #(.DATA_W(8), .N_TAPS(4), .OUT_SHIFT(0), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .pixels(pixels), .convResult(res_relu)
  );

  typedef struct {
    logic [7:0] e;
    logic [7:0] er;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drive(input logic r, input logic [31:0] k, input logic [31:0] p,
                       input logic [7:0] e, input logic [7:0] er, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    kernel = k;
    pixels = p;
    x.e = e; x.er = er; x.nm = nm;
    sb.push_back(x);
  endtask

  // Each entry is popped one edge after being driven and checked on the next edge.
  initial begin
    exp_t pend;
    bit   have = 1'b0;
    bit   rst_seen;
    logic [7:0] want, want_r;
    forever begin
      @(posedge clk);
      rst_seen = !rst_n;
      #1;
      if (have) begin
        want   = rst_seen ? 8'h00 : pend.e;
        want_r = rst_seen ? 8'h00 : pend.er;
        total++;
        if (res !== want) begin
          bad++;
          $display("FAIL %s: convResult got %h expected %h", pend.nm, res, want);
        end
        total++;
        if (res_relu !== want_r) begin
          bad++;
          $display("FAIL %s_relu: convResult got %h expected %h", pend.nm, res_relu, want_r);
        end
      end
      if (sb.size() > 0) begin
        pend = sb.pop_front();
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation got stuck expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    kernel = '0;
    pixels = '0;
    repeat (3) drive(1'b0, 32'h0, 32'h0, 8'h00, 8'h00, "reset");

    drive(1'b1, 32'h01ffff01, 32'h01ffff01, 8'h04, 8'h04, "t1_pos4");
    drive(1'b1, 32'h01ffff01, 32'hff0101ff, 8'hfc, 8'h00, "t2_neg4");
    drive(1'b1, 32'h01ffff01, 32'h01010101, 8'h00, 8'h00, "t2_ones");
    drive(1'b1, 32'h01ffff01, 32'hffffffff, 8'h00, 8'h00, "t2_minus_ones");
    drive(1'b1, 32'h05fbfb05, 32'h01ffff01, 8'h14, 8'h14, "t3_pos20");
    drive(1'b1, 32'h05fbfb05, 32'hff0101ff, 8'hec, 8'h00, "t3_neg20");
    drive(1'b1, 32'h80808080, 32'h80808080, 8'h7f, 8'h7f, "sat_pos");
    drive(1'b1, 32'h80808080, 32'h7f7f7f7f, 8'h80, 8'h00, "sat_neg");
    drive(1'b1, 32'h01020304, 32'h01020304, 8'h1e, 8'h1e, "tap_order");
    drive(1'b1, 32'h7f000000, 32'h01000000, 8'h7f, 8'h7f, "edge_127");
    drive(1'b1, 32'h80000000, 32'hff000000, 8'h7f, 8'h7f, "edge_128");
    drive(1'b1, 32'h00000080, 32'h00000001, 8'h80, 8'h00, "edge_m128");
    drive(1'b1, 32'h0000ff80, 32'h00000101, 8'h80, 8'h00, "edge_m129");

    // Back-to-back with only pixels changing, so the held kernel is reused.
    drive(1'b1, 32'h01ffff01, 32'h01ffff01, 8'h04, 8'h04, "b2b_a");
    drive(1'b1, 32'h01ffff01, 32'hff0101ff, 8'hfc, 8'h00, "b2b_b");
    drive(1'b1, 32'h05fbfb05, 32'hff0101ff, 8'hec, 8'h00, "b2b_c");
    drive(1'b1, 32'h05fbfb05, 32'h01ffff01, 8'h14, 8'h14, "b2b_d");

    // Mid-stream reset: in-flight results and the reset-cycle data are discarded.
    drive(1'b0, 32'h05fbfb05, 32'h01ffff01, 8'h00, 8'h00, "mid_reset");
    drive(1'b1, 32'h01ffff01, 32'h01ffff01, 8'h04, 8'h04, "resume_a");
    drive(1'b1, 32'h05fbfb05, 32'hff0101ff, 8'hec, 8'h00, "resume_b");
    drive(1'b1, 32'h80808080, 32'h80808080, 8'h7f, 8'h7f, "resume_c");

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending entries got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
